// File: rtl/score_hex_display.sv
// Score/level seven-segment driver: sequential double-dabble converts user_score to
// three BCD digits; level is shown as a hex glyph on hex3.
//
// state | meaning
// IDLE  | watching user_score/level for a change against the shadows
// SHIFT | one add-3/shift step per clock, SCORE_W steps total
// DONE  | result loaded into digit regs, one cycle before IDLE
module score_hex_display #(
    parameter int SCORE_W        = 7,
    parameter int LEVEL_W        = 4,
    parameter bit HEX_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] user_score,
    input  logic [LEVEL_W-1:0] level,
    input  logic               blank,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic               busy
);

    localparam int BCD_W = 12;
    localparam int SH_W  = BCD_W + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [6:0] DARK = HEX_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic               start, load;
    logic               valid_q;
    logic [SCORE_W-1:0] score_sh;
    logic [LEVEL_W-1:0] level_sh;
    logic [SH_W-1:0]    shreg, shreg_adj, shreg_nx;
    logic [CNT_W-1:0]   bitcnt;
    logic [3:0]         dig_h, dig_t, dig_u, dig_l;
    logic [6:0]         hex0_d, hex1_d, hex2_d, hex3_d;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return HEX_ACTIVE_LOW ? ~s : s;
    endfunction

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!valid_q || user_score != score_sh || level != level_sh) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (bitcnt == '0) begin
                    state_d = DONE;
                    load    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble, then shift left, all in one cycle.
    always_comb begin
        shreg_adj = shreg;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (shreg[SCORE_W + 4*i +: 4] >= 4'd5)
                shreg_adj[SCORE_W + 4*i +: 4] = shreg[SCORE_W + 4*i +: 4] + 4'd3;
        end
        shreg_nx = shreg_adj << 1;
    end

    always_comb begin
        hex0_d = seg7(dig_u);
        hex1_d = (dig_h == 4'd0 && dig_t == 4'd0) ? DARK : seg7(dig_t);
        hex2_d = (dig_h == 4'd0) ? DARK : seg7(dig_h);
        hex3_d = seg7(dig_l);
        if (blank) begin
            hex0_d = DARK;
            hex1_d = DARK;
            hex2_d = DARK;
            hex3_d = DARK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            score_sh <= '0;
            level_sh <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            dig_h    <= '0;
            dig_t    <= '0;
            dig_u    <= '0;
            dig_l    <= '0;
            hex0     <= DARK;
            hex1     <= DARK;
            hex2     <= DARK;
            hex3     <= DARK;
        end else begin
            state_q <= state_d;
            if (start) begin
                score_sh <= user_score;
                level_sh <= level;
                shreg    <= {{BCD_W{1'b0}}, user_score};
                bitcnt   <= CNT_W'(SCORE_W - 1);
            end else if (state_q == SHIFT) begin
                shreg  <= shreg_nx;
                bitcnt <= bitcnt - 1'b1;
            end
            // Level digit latched with the score so all four digits change together.
            if (load) begin
                dig_u   <= shreg_nx[SCORE_W     +: 4];
                dig_t   <= shreg_nx[SCORE_W + 4 +: 4];
                dig_h   <= shreg_nx[SCORE_W + 8 +: 4];
                dig_l   <= 4'(level_sh);
                valid_q <= 1'b1;
            end
            hex0 <= hex0_d;
            hex1 <= hex1_d;
            hex2 <= hex2_d;
            hex3 <= hex3_d;
        end
    end

    assign busy = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_score_hex_display.sv
// Bench for score_hex_display: decimal/hex glyph model feeds a scoreboard queue that is
// popped whenever a conversion finishes (busy falls).
module tb_score_hex_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] user_score;
    logic [3:0] level;
    logic       blank;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [27:0] exp_q[$];
    logic [27:0] exp_w;
    int n;

    score_hex_display dut (
        .clk        (clk),
        .reset      (reset),
        .user_score (user_score),
        .level      (level),
        .blank      (blank),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam logic [27:0] ALL_DARK = {4{7'h7F}};

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] s;
        case (v)
            0: s = 7'h3F;  1: s = 7'h06;  2: s = 7'h5B;  3: s = 7'h4F;
            4: s = 7'h66;  5: s = 7'h6D;  6: s = 7'h7D;  7: s = 7'h07;
            8: s = 7'h7F;  9: s = 7'h6F;  10: s = 7'h77; 11: s = 7'h7C;
            12: s = 7'h39; 13: s = 7'h5E; 14: s = 7'h79; default: s = 7'h71;
        endcase
        return ~s;
    endfunction

    function automatic logic [27:0] model(input int s, input int l);
        int h, t, u;
        logic [6:0] g2, g1;
        h = s / 100;
        t = (s / 10) % 10;
        u = s % 10;
        g2 = (h == 0) ? 7'h7F : glyph(h);
        g1 = (h == 0 && t == 0) ? 7'h7F : glyph(t);
        return {glyph(l), g2, g1, glyph(u)};
    endfunction

    function automatic logic [27:0] hex_word();
        return {hex3, hex2, hex1, hex0};
    endfunction

    // Counts negedges with busy high, stopping on the first idle negedge or the bound.
    task automatic wait_busy(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic drive(input int s, input int l);
        user_score = 7'(s);
        level      = 4'(l);
        exp_q.push_back(model(s, l));
    endtask

    task automatic pop_exp(output logic [27:0] w);
        if (exp_q.size() == 0) begin
            w = 'x;
            bad++;
            total++;
            $display("FAIL scoreboard_empty: actual=%h required=expected entry", hex_word());
        end else begin
            w = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; blank = 1'b0; user_score = '0; level = '0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (hex_word() !== ALL_DARK) begin
            bad++; $display("FAIL reset_hex: actual=%h required=%h", hex_word(), ALL_DARK);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: actual=%b required=0", busy);
        end
        exp_q.push_back(model(0, 0));
        reset = 1'b0;
        wait_busy(n);
        total++;
        if (n != 8) begin
            bad++; $display("FAIL reset_latency: actual=%0d required=8", n);
        end
        pop_exp(exp_w);
        total++;
        if (hex_word() !== exp_w) begin
            bad++; $display("FAIL reset_zero: actual=%h required=%h", hex_word(), exp_w);
        end
    endtask

    task automatic test_max();
        drive(127, 9);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL max_busy_next: actual=%b required=1", busy);
        end
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        total++;
        if (n != 8) begin
            bad++; $display("FAIL max_latency: actual=%0d required=8", n);
        end
        pop_exp(exp_w);
        total++;
        if (hex_word() !== exp_w) begin
            bad++; $display("FAIL max_127: actual=%h required=%h", hex_word(), exp_w);
        end
    endtask

    task automatic test_values();
        int vals[3] = '{10, 100, 42};
        for (int i = 0; i < 3; i++) begin
            drive(vals[i], 3);
            wait_busy(n);
            total++;
            if (n != 8) begin
                bad++; $display("FAIL values_latency_%0d: actual=%0d required=8", vals[i], n);
            end
            pop_exp(exp_w);
            total++;
            if (hex_word() !== exp_w) begin
                bad++; $display("FAIL values_%0d: actual=%h required=%h", vals[i], hex_word(), exp_w);
            end
        end
    endtask

    task automatic test_blank();
        blank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (hex_word() !== ALL_DARK || busy !== 1'b0) begin
                bad++;
                $display("FAIL blank_dark_%0d: actual=%h busy=%b required=%h busy=0",
                         i, hex_word(), busy, ALL_DARK);
            end
        end
        blank = 1'b0;
        exp_q.push_back(model(42, 3));
        @(negedge clk);
        pop_exp(exp_w);
        total++;
        if (hex_word() !== exp_w || busy !== 1'b0) begin
            bad++;
            $display("FAIL blank_restore: actual=%h busy=%b required=%h busy=0",
                     hex_word(), busy, exp_w);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        drive(5, 2);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        drive(6, 2);
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        total++;
        if (n != 8) begin
            bad++; $display("FAIL b2b_first_latency: actual=%0d required=8", n);
        end
        pop_exp(exp_w);
        total++;
        if (hex_word() !== exp_w) begin
            bad++; $display("FAIL b2b_first_5: actual=%h required=%h", hex_word(), exp_w);
        end
        gap = 1;
        @(negedge clk);
        while (busy !== 1'b1 && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        total++;
        if (gap != 1) begin
            bad++; $display("FAIL b2b_idle_gap: actual=%0d required=1", gap);
        end
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        total++;
        if (n != 8) begin
            bad++; $display("FAIL b2b_second_latency: actual=%0d required=8", n);
        end
        pop_exp(exp_w);
        total++;
        if (hex_word() !== exp_w) begin
            bad++; $display("FAIL b2b_second_6: actual=%h required=%h", hex_word(), exp_w);
        end
    endtask

    task automatic test_reset_mid();
        user_score = 7'd99;
        level      = 4'd7;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (hex_word() !== ALL_DARK || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_dark: actual=%h busy=%b required=%h busy=0",
                     hex_word(), busy, ALL_DARK);
        end
        reset = 1'b0;
        exp_q.push_back(model(99, 7));
        wait_busy(n);
        total++;
        if (n != 8) begin
            bad++; $display("FAIL midreset_latency: actual=%0d required=8", n);
        end
        pop_exp(exp_w);
        total++;
        if (hex_word() !== exp_w) begin
            bad++; $display("FAIL midreset_99: actual=%h required=%h", hex_word(), exp_w);
        end
    endtask

    task automatic test_random();
        int s, l;
        for (int i = 0; i < 8; i++) begin
            do begin
                s = $urandom_range(0, 127);
                l = (i < 6) ? 10 + i : $urandom_range(0, 15);
            end while (s == int'(user_score) && l == int'(level));
            drive(s, l);
            wait_busy(n);
            total++;
            if (n != 8) begin
                bad++; $display("FAIL rand_latency_%0d: actual=%0d required=8", i, n);
            end
            pop_exp(exp_w);
            total++;
            if (hex_word() !== exp_w) begin
                bad++;
                $display("FAIL rand_%0d_s%0d_l%0d: actual=%h required=%h", i, s, l, hex_word(), exp_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_values();
        test_blank();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
